// File: rtl/lcd_char_driver.sv
// HD44780 16x2 character LCD driver, 8-bit write-only: power-up init, then endless
// refresh of both lines from the character-list block via index/char_in.
module lcd_char_driver #(
    parameter int TICK_DIV      = 50000,
    parameter int POWERUP_SLOTS = 20,
    parameter int CLEAR_SLOTS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(2);
    localparam logic [CW-1:0] E_ON     = CW'(4);
    localparam logic [CW-1:0] E_OFF    = CW'(TICK_DIV / 2);
    localparam logic [15:0]   PWR_LAST = 16'(POWERUP_SLOTS - 1);
    localparam logic [15:0]   CLR_LAST = 16'(CLEAR_SLOTS - 1);
    localparam logic [15:0]   INIT_LAST = 16'd3;
    localparam logic [15:0]   LINE_LAST = 16'd15;

    typedef enum logic [2:0] {
        S_POWERUP  = 3'd0,
        S_INIT     = 3'd1,
        S_CLR_WAIT = 3'd2,
        S_ADDR1    = 3'd3,
        S_LINE1    = 3'd4,
        S_ADDR2    = 3'd5,
        S_LINE2    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   sub_q, sub_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    index_q, index_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          e_q, e_d;
    logic          init_done_q, init_done_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_end_s;
    logic          write_slot_s;
    logic          data_slot_s;
    logic [7:0]    cmd_byte_s;

    // State, slot timer and registered LCD-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_POWERUP;
            sub_q        <= 16'd0;
            cnt_q        <= '0;
            index_q      <= 5'd0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            e_q          <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sub_q        <= sub_d;
            cnt_q        <= cnt_d;
            index_q      <= index_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            e_q          <= e_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: slot timing within a slot, state sequencing at slot end.
    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        index_d      = index_q;
        rs_d         = rs_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        cmd_byte_s   = 8'h00;

        slot_end_s   = (cnt_q == CNT_LAST);
        data_slot_s  = (state_q == S_LINE1) || (state_q == S_LINE2);
        write_slot_s = data_slot_s || (state_q == S_INIT) ||
                       (state_q == S_ADDR1) || (state_q == S_ADDR2);

        if (slot_end_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_INIT: begin
                case (sub_q[1:0])
                    2'd0:    cmd_byte_s = 8'h38;
                    2'd1:    cmd_byte_s = 8'h0C;
                    2'd2:    cmd_byte_s = 8'h06;
                    default: cmd_byte_s = 8'h01;
                endcase
            end
            S_ADDR1: cmd_byte_s = 8'h80;
            S_ADDR2: cmd_byte_s = 8'hC0;
            default: cmd_byte_s = 8'h00;
        endcase

        if (data_slot_s && (cnt_q == '0)) begin
            index_d = {(state_q == S_LINE2), sub_q[3:0]};
        end else begin
            index_d = index_q;
        end

        // char_in reflects the index set at cnt 0 by cnt 2 (one-clk list latency).
        if (write_slot_s && (cnt_q == CNT_LOAD)) begin
            rs_d   = data_slot_s;
            data_d = data_slot_s ? char_in : cmd_byte_s;
        end else begin
            rs_d   = rs_q;
            data_d = data_q;
        end

        e_d = write_slot_s && (cnt_d >= E_ON) && (cnt_d < E_OFF);

        if (slot_end_s) begin
            sub_d = sub_q + 16'd1;
            case (state_q)
                S_POWERUP: begin
                    if (sub_q == PWR_LAST) begin
                        state_d = S_INIT;
                        sub_d   = 16'd0;
                    end else begin
                        state_d = S_POWERUP;
                    end
                end
                S_INIT: begin
                    if (sub_q == INIT_LAST) begin
                        state_d = S_CLR_WAIT;
                        sub_d   = 16'd0;
                    end else begin
                        state_d = S_INIT;
                    end
                end
                S_CLR_WAIT: begin
                    if (sub_q == CLR_LAST) begin
                        state_d     = S_ADDR1;
                        sub_d       = 16'd0;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = S_CLR_WAIT;
                    end
                end
                S_ADDR1: begin
                    state_d = S_LINE1;
                    sub_d   = 16'd0;
                end
                S_LINE1: begin
                    if (sub_q == LINE_LAST) begin
                        state_d = S_ADDR2;
                        sub_d   = 16'd0;
                    end else begin
                        state_d = S_LINE1;
                    end
                end
                S_ADDR2: begin
                    state_d = S_LINE2;
                    sub_d   = 16'd0;
                end
                S_LINE2: begin
                    if (sub_q == LINE_LAST) begin
                        state_d      = S_ADDR1;
                        sub_d        = 16'd0;
                        frame_done_d = 1'b1;
                        index_d      = 5'd0;
                    end else begin
                        state_d = S_LINE2;
                    end
                end
                default: begin
                    state_d = S_POWERUP;
                    sub_d   = 16'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign index      = index_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = e_q;
    assign lcd_data   = data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver with a registered character-list stub
// (char_in = offset + index); captures bus bytes on every lcd_e falling edge.
module tb_lcd_char_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
    logic [7:0] lcd_data;
    logic [7:0] offset = 8'h40;

    int n_assert = 0;
    int n_fail   = 0;

    lcd_char_driver #(.TICK_DIV(16), .POWERUP_SLOTS(3), .CLEAR_SLOTS(2)) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .index(index),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Character-list stub, one clock of latency after index.
    always @(posedge clk or negedge rst) begin
        if (!rst) char_in <= 8'h00;
        else      char_in <= offset + {3'b000, index};
    end

    logic [7:0] cap_b  [0:255];
    logic       cap_rs [0:255];
    int         cap_n = 0;

    // Capture the latched byte whenever the enable strobe falls (not due to reset).
    always @(negedge lcd_e) begin
        if (rst && cap_n < 256) begin
            cap_b[cap_n]  <= lcd_data;
            cap_rs[cap_n] <= lcd_rs;
            cap_n         <= cap_n + 1;
        end
    end

    int   cyc = 0, e_run = 0, e_wmin = 1000, e_wmax = 0;
    int   fd_run = 0, fd_wmax = 0, fd_cnt = 0, fd_last = 0, fd_prev = 0;
    logic rw_high = 1'b0;

    // Pulse-width, frame_done spacing and lcd_rw monitors.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        e_run <= lcd_e ? e_run + 1 : 0;
        if (!lcd_e && e_run != 0 && rst) begin
            if (e_run < e_wmin) e_wmin <= e_run;
            if (e_run > e_wmax) e_wmax <= e_run;
        end
        fd_run <= frame_done ? fd_run + 1 : 0;
        if (frame_done && fd_run == 0) begin
            fd_cnt  <= fd_cnt + 1;
            fd_prev <= fd_last;
            fd_last <= cyc;
        end
        if (frame_done && fd_run + 1 > fd_wmax) fd_wmax <= fd_run + 1;
        if (lcd_rw) rw_high <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_caps(input int n, input int budget, input string tag);
        int k = 0;
        while (cap_n < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(cap_n >= n), 32'd1);
    endtask

    // Expected {rs, byte} at position p of a 34-slot refresh frame.
    function automatic logic [8:0] frame_exp(input int p, input logic [7:0] off);
        if (p == 0)       return {1'b0, 8'h80};
        else if (p <= 16) return {1'b1, off + 8'(p - 1)};
        else if (p == 17) return {1'b0, 8'hC0};
        else              return {1'b1, off + 8'(p - 2)};
    endfunction

    task automatic chk_init(input int base);
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'h38; exp_b[1] = 8'h0C; exp_b[2] = 8'h06; exp_b[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("init_byte%0d", i), 32'(cap_b[base + i]), 32'(exp_b[i]));
            chk($sformatf("init_rs%0d", i), 32'(cap_rs[base + i]), 32'd0);
        end
    endtask

    initial begin
        int base;
        logic [8:0] ev;
        logic [7:0] off;

        repeat (10) @(negedge clk);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'h00);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b1;

        repeat (48) @(negedge clk);
        chk("powerup_no_e", 32'(cap_n), 32'd0);
        chk("powerup_e_low", 32'(lcd_e), 32'd0);

        wait_caps(4, 100, "init_timeout");
        chk_init(0);
        chk("init_done_early", 32'(init_done), 32'd0);
        repeat (39) @(negedge clk);
        chk("clr_wait_no_e", 32'(cap_n), 32'd4);
        chk("init_done_before", 32'(init_done), 32'd0);
        @(negedge clk);
        chk("init_done_rise", 32'(init_done), 32'd1);

        wait_caps(38, 34 * 16 + 32, "frame1_timeout");
        for (int c = 4; c < 38; c++) begin
            ev = frame_exp(c - 4, 8'h40);
            chk($sformatf("f1_byte%0d", c - 4), 32'(cap_b[c]), 32'(ev[7:0]));
            chk($sformatf("f1_rs%0d", c - 4), 32'(cap_rs[c]), 32'(ev[8]));
        end

        base = 0;
        while (fd_cnt < 1 && base < 64) begin
            @(negedge clk);
            base++;
        end
        chk("fd_first", 32'(fd_cnt), 32'd1);
        wait_caps(39, 64, "wrap_timeout");
        chk("wrap_byte", 32'(cap_b[38]), 32'h80);
        chk("wrap_rs", 32'(cap_rs[38]), 32'd0);
        chk("wrap_init_done", 32'(init_done), 32'd1);

        wait_caps(49, 16 * 16, "mid_frame_timeout");
        offset = 8'h30;

        wait_caps(106, 2 * 34 * 16 + 64, "frame3_timeout");
        for (int c = 38; c < 106; c++) begin
            off = (c <= 48) ? 8'h40 : 8'h30;
            ev  = frame_exp((c - 38) % 34, off);
            chk($sformatf("f23_byte%0d", c - 38), 32'(cap_b[c]), 32'(ev[7:0]));
            chk($sformatf("f23_rs%0d", c - 38), 32'(cap_rs[c]), 32'(ev[8]));
        end

        base = 0;
        while (fd_cnt < 3 && base < 64) begin
            @(negedge clk);
            base++;
        end
        chk("fd_count", 32'(fd_cnt), 32'd3);
        chk("fd_period", 32'(fd_last - fd_prev), 32'd544);
        chk("fd_width", 32'(fd_wmax), 32'd1);
        chk("e_width_min", 32'(e_wmin), 32'd4);
        chk("e_width_max", 32'(e_wmax), 32'd4);
        chk("rw_never_high", 32'(rw_high), 32'd0);

        wait_caps(108, 64, "line1_timeout");
        base = 0;
        while (lcd_e !== 1'b1 && base < 32) begin
            @(negedge clk);
            base++;
        end
        chk("e_high_before_rst", 32'(lcd_e), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_e", 32'(lcd_e), 32'd0);
        chk("async_rst_init_done", 32'(init_done), 32'd0);
        chk("async_rst_data", 32'(lcd_data), 32'h00);
        chk("async_rst_index", 32'(index), 32'd0);
        base = cap_n;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (48) @(negedge clk);
        chk("reinit_powerup_no_e", 32'(cap_n), 32'(base));
        wait_caps(base + 4, 100, "reinit_timeout");
        chk_init(base);
        chk("reinit_init_done", 32'(init_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
